// File: rtl/sdram_arb_pkg.sv
// Shared state encoding and master indices for the two-master SDRAM Wishbone arbiter.
package sdram_arb_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_GNT0 = 2'd1,
    ST_GNT1 = 2'd2
  } arb_state_e;

  localparam logic M0 = 1'b0;
  localparam logic M1 = 1'b1;

  function automatic logic [1:0] grant_of(arb_state_e st);
    case (st)
      ST_GNT0: grant_of = 2'b01;
      ST_GNT1: grant_of = 2'b10;
      default: grant_of = 2'b00;
    endcase
  endfunction

endpackage

// File: rtl/wb_sdram_arbiter.sv
// Round-robin arbiter giving a CPU (m0) and a DMA (m1) Wishbone master access to one
// SDRAM slave, with a stall watchdog that turns a hung access into a bus error.
module wb_sdram_arbiter
  import sdram_arb_pkg::*;
#(
  parameter int unsigned TIMEOUT = 255
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        m0_cyc_i,
  input  logic        m0_stb_i,
  input  logic        m0_we_i,
  input  logic [3:0]  m0_sel_i,
  input  logic [31:0] m0_adr_i,
  input  logic [31:0] m0_dat_i,
  output logic        m0_ack_o,
  output logic        m0_err_o,
  output logic [31:0] m0_dat_o,
  input  logic        m1_cyc_i,
  input  logic        m1_stb_i,
  input  logic        m1_we_i,
  input  logic [3:0]  m1_sel_i,
  input  logic [31:0] m1_adr_i,
  input  logic [31:0] m1_dat_i,
  output logic        m1_ack_o,
  output logic        m1_err_o,
  output logic [31:0] m1_dat_o,
  output logic        s_cyc_o,
  output logic        s_stb_o,
  output logic        s_we_o,
  output logic [3:0]  s_sel_o,
  output logic [31:0] s_adr_o,
  output logic [31:0] s_dat_o,
  input  logic        s_ack_i,
  input  logic [31:0] s_dat_i,
  output logic [1:0]  grant_o
);

  localparam logic [15:0] TIMEOUT_W = 16'(TIMEOUT);

  arb_state_e  state, state_nxt;
  logic        last, last_nxt;
  logic [15:0] wd;
  logic        armed;
  logic        g0, g1, req_cyc, req_stb, expire;

  assign g0 = (state == ST_GNT0);
  assign g1 = (state == ST_GNT1);

  assign req_cyc = (g0 & m0_cyc_i) | (g1 & m1_cyc_i);
  assign req_stb = (g0 & m0_stb_i) | (g1 & m1_stb_i);
  // An ack landing in the expiry cycle completes the access instead of erroring it.
  assign expire  = req_stb & ~s_ack_i & (wd == TIMEOUT_W);

  assign s_cyc_o = req_cyc & ~expire;
  assign s_stb_o = req_stb & ~expire;
  assign s_we_o  = (g0 & m0_we_i) | (g1 & m1_we_i);
  assign s_sel_o = ({4{g0}} & m0_sel_i) | ({4{g1}} & m1_sel_i);
  assign s_adr_o = ({32{g0}} & m0_adr_i) | ({32{g1}} & m1_adr_i);
  assign s_dat_o = ({32{g0}} & m0_dat_i) | ({32{g1}} & m1_dat_i);

  assign m0_ack_o = g0 & s_ack_i;
  assign m0_err_o = g0 & expire;
  assign m0_dat_o = {32{g0}} & s_dat_i;
  assign m1_ack_o = g1 & s_ack_i;
  assign m1_err_o = g1 & expire;
  assign m1_dat_o = {32{g1}} & s_dat_i;

  always_comb begin
    state_nxt = state;
    last_nxt  = last;
    case (state)
      ST_IDLE: begin
        // armed holds off the first grant until the second edge after reset release.
        if (armed) begin
          if (m0_cyc_i && (!m1_cyc_i || last == M1)) begin
            state_nxt = ST_GNT0;
            last_nxt  = M0;
          end else if (m1_cyc_i) begin
            state_nxt = ST_GNT1;
            last_nxt  = M1;
          end
        end
      end
      ST_GNT0: begin
        if (!m0_cyc_i) begin
          if (m1_cyc_i) begin
            state_nxt = ST_GNT1;
            last_nxt  = M1;
          end else begin
            state_nxt = ST_IDLE;
          end
        end
      end
      ST_GNT1: begin
        if (!m1_cyc_i) begin
          if (m0_cyc_i) begin
            state_nxt = ST_GNT0;
            last_nxt  = M0;
          end else begin
            state_nxt = ST_IDLE;
          end
        end
      end
      default: state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state   <= ST_IDLE;
      last    <= M1;
      wd      <= '0;
      armed   <= 1'b0;
      grant_o <= 2'b00;
    end else begin
      state   <= state_nxt;
      last    <= last_nxt;
      armed   <= 1'b1;
      grant_o <= grant_of(state_nxt);
      if (state_nxt != state || s_ack_i || expire) begin
        wd <= '0;
      end else if (s_stb_o) begin
        wd <= wd + 16'd1;
      end
    end
  end

endmodule

// File: tb/tb_wb_sdram_arbiter.sv
// Self-checking bench for wb_sdram_arbiter: scenario tasks with inline checks plus a
// read-data scoreboard that matches every master ack against an expected queue.
module tb_wb_sdram_arbiter;

  localparam int unsigned TIMEOUT = 8;

  logic        clk = 1'b0;
  logic        rst;
  logic        m0_cyc, m0_stb, m0_we;
  logic [3:0]  m0_sel;
  logic [31:0] m0_adr, m0_wdat;
  logic        m0_ack, m0_err;
  logic [31:0] m0_rdat;
  logic        m1_cyc, m1_stb, m1_we;
  logic [3:0]  m1_sel;
  logic [31:0] m1_adr, m1_wdat;
  logic        m1_ack, m1_err;
  logic [31:0] m1_rdat;
  logic        s_cyc, s_stb, s_we;
  logic [3:0]  s_sel;
  logic [31:0] s_adr, s_wdat;
  logic        s_ack;
  logic [31:0] s_rdat;
  logic [1:0]  grant;

  int          pass_cnt = 0;
  int          total_cnt = 0;
  logic [32:0] exp_q[$];
  logic [32:0] sb_got, sb_exp;

  wb_sdram_arbiter #(.TIMEOUT(TIMEOUT)) dut (
    .clk(clk), .rst(rst),
    .m0_cyc_i(m0_cyc), .m0_stb_i(m0_stb), .m0_we_i(m0_we), .m0_sel_i(m0_sel),
    .m0_adr_i(m0_adr), .m0_dat_i(m0_wdat), .m0_ack_o(m0_ack), .m0_err_o(m0_err),
    .m0_dat_o(m0_rdat),
    .m1_cyc_i(m1_cyc), .m1_stb_i(m1_stb), .m1_we_i(m1_we), .m1_sel_i(m1_sel),
    .m1_adr_i(m1_adr), .m1_dat_i(m1_wdat), .m1_ack_o(m1_ack), .m1_err_o(m1_err),
    .m1_dat_o(m1_rdat),
    .s_cyc_o(s_cyc), .s_stb_o(s_stb), .s_we_o(s_we), .s_sel_o(s_sel),
    .s_adr_o(s_adr), .s_dat_o(s_wdat), .s_ack_i(s_ack), .s_dat_i(s_rdat),
    .grant_o(grant)
  );

  // clock / reset
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL global_timeout got=running exp=finished");
    $fatal(1);
  end

  // scoreboard: every master ack must match the head of the expected queue {master, data}
  always @(negedge clk) begin
    if (m0_ack || m1_ack) begin
      sb_got = m1_ack ? {1'b1, m1_rdat} : {1'b0, m0_rdat};
      total_cnt++;
      if (m0_ack && m1_ack) begin
        $display("FAIL sb_double_ack got=both exp=one");
      end else if (exp_q.size() == 0) begin
        $display("FAIL sb_unexpected got=%h exp=none", sb_got);
      end else begin
        sb_exp = exp_q.pop_front();
        if (sb_got !== sb_exp) $display("FAIL sb_data got=%h exp=%h", sb_got, sb_exp);
        else pass_cnt++;
      end
    end
  end

  // driver tasks
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_masters();
    m0_cyc = 0; m0_stb = 0; m0_we = 0; m0_sel = 4'h0; m0_adr = '0; m0_wdat = '0;
    m1_cyc = 0; m1_stb = 0; m1_we = 0; m1_sel = 4'h0; m1_adr = '0; m1_wdat = '0;
    s_ack = 0; s_rdat = '0;
  endtask

  task automatic m0_req(input logic [31:0] adr);
    m0_cyc = 1; m0_stb = 1; m0_we = 0; m0_sel = 4'hf; m0_adr = adr;
  endtask

  task automatic m1_req(input logic [31:0] adr);
    m1_cyc = 1; m1_stb = 1; m1_we = 0; m1_sel = 4'hf; m1_adr = adr;
  endtask

  task automatic test_reset();
    rst = 0;
    m0_req(32'h0000_0010);
    @(negedge clk);
    total_cnt++; if (grant !== 2'b00) $display("FAIL rst_grant got=%b exp=00", grant); else pass_cnt++;
    total_cnt++; if (s_cyc !== 1'b0) $display("FAIL rst_s_cyc got=%b exp=0", s_cyc); else pass_cnt++;
    step();
    rst = 1;
    step();
    @(negedge clk);
    total_cnt++; if (grant !== 2'b00) $display("FAIL rst_first_edge_grant got=%b exp=00", grant); else pass_cnt++;
    step();
    @(negedge clk);
    total_cnt++; if (grant !== 2'b01) $display("FAIL rst_second_edge_grant got=%b exp=01", grant); else pass_cnt++;
    total_cnt++; if (s_cyc !== 1'b1) $display("FAIL rst_second_edge_cyc got=%b exp=1", s_cyc); else pass_cnt++;
    step();
    idle_masters();
    step();
    @(negedge clk);
    total_cnt++; if (grant !== 2'b00) $display("FAIL rst_back_idle got=%b exp=00", grant); else pass_cnt++;
    step();
  endtask

  task automatic test_single_read();
    m0_req(32'h0000_0010);
    @(negedge clk);
    total_cnt++; if (s_cyc !== 1'b0) $display("FAIL sr_arb_latency got=%b exp=0", s_cyc); else pass_cnt++;
    step();
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      total_cnt++; if (s_adr !== 32'h0000_0010) $display("FAIL sr_s_adr got=%h exp=00000010", s_adr); else pass_cnt++;
      total_cnt++; if (m0_ack !== 1'b0) $display("FAIL sr_early_ack got=%b exp=0", m0_ack); else pass_cnt++;
      step();
    end
    s_ack = 1; s_rdat = 32'h1234_5678;
    exp_q.push_back({1'b0, 32'h1234_5678});
    @(negedge clk);
    total_cnt++; if (m0_rdat !== 32'h1234_5678) $display("FAIL sr_m0_dat got=%h exp=12345678", m0_rdat); else pass_cnt++;
    total_cnt++; if (grant !== 2'b01) $display("FAIL sr_grant got=%b exp=01", grant); else pass_cnt++;
    total_cnt++; if (m1_ack !== 1'b0) $display("FAIL sr_m1_ack got=%b exp=0", m1_ack); else pass_cnt++;
    total_cnt++; if (m1_rdat !== 32'h0) $display("FAIL sr_m1_dat got=%h exp=0", m1_rdat); else pass_cnt++;
    step();
    idle_masters();
    step();
    step();
  endtask

  task automatic test_round_robin();
    rst = 0;
    step();
    rst = 1;
    m0_req(32'h0000_0100);
    m1_req(32'h0000_0200);
    step();
    step();
    s_ack = 1; s_rdat = 32'hA0A0_0001;
    exp_q.push_back({1'b0, 32'hA0A0_0001});
    @(negedge clk);
    total_cnt++; if (grant !== 2'b01) $display("FAIL rr_first_tie got=%b exp=01", grant); else pass_cnt++;
    total_cnt++; if (s_adr !== 32'h0000_0100) $display("FAIL rr_first_adr got=%h exp=00000100", s_adr); else pass_cnt++;
    step();
    m0_cyc = 0; m0_stb = 0; s_ack = 0;
    @(negedge clk);
    total_cnt++; if (s_cyc !== 1'b0) $display("FAIL rr_drop_cyc got=%b exp=0", s_cyc); else pass_cnt++;
    step();
    s_ack = 1; s_rdat = 32'hB1B1_0002;
    exp_q.push_back({1'b1, 32'hB1B1_0002});
    @(negedge clk);
    total_cnt++; if (grant !== 2'b10) $display("FAIL rr_direct_handover got=%b exp=10", grant); else pass_cnt++;
    total_cnt++; if (s_adr !== 32'h0000_0200) $display("FAIL rr_m1_adr got=%h exp=00000200", s_adr); else pass_cnt++;
    step();
    m0_req(32'h0000_0300);
    m1_cyc = 0; m1_stb = 0; s_ack = 0;
    step();
    s_ack = 1; s_rdat = 32'hC2C2_0003;
    exp_q.push_back({1'b0, 32'hC2C2_0003});
    @(negedge clk);
    total_cnt++; if (grant !== 2'b01) $display("FAIL rr_back_handover got=%b exp=01", grant); else pass_cnt++;
    step();
    m0_cyc = 0; m0_stb = 0; s_ack = 0;
    step();
    m0_req(32'h0000_0100);
    m1_req(32'h0000_0200);
    @(negedge clk);
    total_cnt++; if (grant !== 2'b00) $display("FAIL rr_idle_before_tie got=%b exp=00", grant); else pass_cnt++;
    step();
    s_ack = 1; s_rdat = 32'hD3D3_0004;
    exp_q.push_back({1'b1, 32'hD3D3_0004});
    @(negedge clk);
    total_cnt++; if (grant !== 2'b10) $display("FAIL rr_second_tie got=%b exp=10", grant); else pass_cnt++;
    total_cnt++; if (s_adr !== 32'h0000_0200) $display("FAIL rr_second_tie_adr got=%h exp=00000200", s_adr); else pass_cnt++;
    step();
    idle_masters();
    step();
    step();
  endtask

  task automatic test_burst();
    logic [31:0] base;
    logic [31:0] dat;
    base = 32'h0001_0000 + 32'($urandom_range(0, 255)) * 32'd16;
    m1_req(base);
    step();
    m0_req(32'h0000_0040);
    for (int beat = 0; beat < 4; beat++) begin
      if (beat == 2) begin
        s_ack = 0;
        @(negedge clk);
        total_cnt++; if (m0_ack !== 1'b0) $display("FAIL bu_m0_ack_stall got=%b exp=0", m0_ack); else pass_cnt++;
        step();
      end
      m1_adr = base + 32'(beat) * 32'd4;
      dat = $urandom();
      s_ack = 1; s_rdat = dat;
      exp_q.push_back({1'b1, dat});
      @(negedge clk);
      total_cnt++; if (grant !== 2'b10) $display("FAIL bu_grant got=%b exp=10", grant); else pass_cnt++;
      total_cnt++; if (s_adr !== base + 32'(beat) * 32'd4) $display("FAIL bu_adr got=%h exp=%h", s_adr, base + 32'(beat) * 32'd4); else pass_cnt++;
      step();
    end
    m1_cyc = 0; m1_stb = 0; s_ack = 0;
    step();
    s_ack = 1; s_rdat = 32'h5A5A_0040;
    exp_q.push_back({1'b0, 32'h5A5A_0040});
    @(negedge clk);
    total_cnt++; if (grant !== 2'b01) $display("FAIL bu_m0_after got=%b exp=01", grant); else pass_cnt++;
    total_cnt++; if (s_adr !== 32'h0000_0040) $display("FAIL bu_m0_adr got=%h exp=00000040", s_adr); else pass_cnt++;
    step();
    idle_masters();
    step();
    step();
  endtask

  task automatic test_timeout();
    int err_cnt;
    err_cnt = 0;
    m0_req(32'h0000_0080);
    step();
    for (int c = 1; c <= 10; c++) begin
      @(negedge clk);
      if (m0_err) err_cnt++;
      if (c == 8 || c == 10) begin
        total_cnt++; if (m0_err !== 1'b0 || s_stb !== 1'b1) $display("FAIL to_no_err_c%0d got=err%b/stb%b exp=err0/stb1", c, m0_err, s_stb); else pass_cnt++;
      end
      if (c == 9) begin
        total_cnt++; if (m0_err !== 1'b1) $display("FAIL to_err_pulse got=%b exp=1", m0_err); else pass_cnt++;
        total_cnt++; if (s_stb !== 1'b0 || s_cyc !== 1'b0) $display("FAIL to_stb_forced got=stb%b/cyc%b exp=stb0/cyc0", s_stb, s_cyc); else pass_cnt++;
        total_cnt++; if (grant !== 2'b01) $display("FAIL to_grant_kept got=%b exp=01", grant); else pass_cnt++;
      end
      step();
    end
    total_cnt++; if (err_cnt !== 1) $display("FAIL to_err_count got=%0d exp=1", err_cnt); else pass_cnt++;
    total_cnt++; if (m1_err !== 1'b0) $display("FAIL to_m1_err got=%b exp=0", m1_err); else pass_cnt++;
    idle_masters();
    step();
    step();
  endtask

  task automatic test_ack_at_expiry();
    int err_cnt;
    err_cnt = 0;
    m0_req(32'h0000_00C0);
    step();
    for (int c = 1; c <= 9; c++) begin
      if (c == 9) begin
        s_ack = 1; s_rdat = 32'hFEED_0009;
        exp_q.push_back({1'b0, 32'hFEED_0009});
      end
      @(negedge clk);
      if (m0_err) err_cnt++;
      if (c == 9) begin
        total_cnt++; if (m0_ack !== 1'b1) $display("FAIL ax_ack got=%b exp=1", m0_ack); else pass_cnt++;
        total_cnt++; if (s_stb !== 1'b1) $display("FAIL ax_stb got=%b exp=1", s_stb); else pass_cnt++;
      end
      step();
    end
    total_cnt++; if (err_cnt !== 0) $display("FAIL ax_err_count got=%0d exp=0", err_cnt); else pass_cnt++;
    idle_masters();
    step();
    step();
  endtask

  task automatic test_reset_mid_burst();
    m1_req(32'h0002_0000);
    step();
    s_ack = 1; s_rdat = 32'h7777_0001;
    exp_q.push_back({1'b1, 32'h7777_0001});
    @(negedge clk);
    total_cnt++; if (grant !== 2'b10) $display("FAIL rb_grant_pre got=%b exp=10", grant); else pass_cnt++;
    step();
    m1_adr = 32'h0002_0004;
    s_rdat = 32'h7777_0002;
    rst = 0;
    #1;
    total_cnt++; if (grant !== 2'b00) $display("FAIL rb_grant got=%b exp=00", grant); else pass_cnt++;
    total_cnt++; if ({s_cyc, s_stb, s_we} !== 3'b000) $display("FAIL rb_s_ctl got=%b exp=000", {s_cyc, s_stb, s_we}); else pass_cnt++;
    total_cnt++; if (s_adr !== 32'h0 || s_sel !== 4'h0) $display("FAIL rb_s_adr got=%h/%h exp=0/0", s_adr, s_sel); else pass_cnt++;
    total_cnt++; if (m1_ack !== 1'b0 || m1_rdat !== 32'h0) $display("FAIL rb_m1_out got=%b/%h exp=0/0", m1_ack, m1_rdat); else pass_cnt++;
    step();
    idle_masters();
    rst = 1;
    step();
    step();
  endtask

  initial begin
    rst = 1;
    idle_masters();
    #2;
    test_reset();
    test_single_read();
    test_round_robin();
    test_burst();
    test_timeout();
    test_ack_at_expiry();
    test_reset_mid_burst();
    total_cnt++; if (exp_q.size() != 0) $display("FAIL sb_leftover got=%0d exp=0", exp_q.size()); else pass_cnt++;
    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule

// File: doc/wb_sdram_arbiter.md
WB_SDRAM_ARBITER -- requirements
Module: wb_sdram_arbiter

Interface
REQ-001 SHALL have parameter TIMEOUT, default 255, meaning stalled-cycle limit before a bus error (legal range 1..65535).
REQ-002 SHALL have port clk  input  1  single system clock; all state updates on its rising edge.
REQ-003 SHALL have port rst  input  1  asynchronous, active-low reset.
REQ-004 SHALL have ports m0_cyc_i, m0_stb_i, m0_we_i  input  1 each  Wishbone cycle, strobe and write of master 0 (CPU).
REQ-005 SHALL have ports m0_sel_i  input  4, m0_adr_i and m0_dat_i  input  32  byte select, address and write data of master 0.
REQ-006 SHALL have ports m0_ack_o, m0_err_o  output  1, m0_dat_o  output  32  acknowledge, bus error and read data to master 0.
REQ-007 SHALL have the port set m1_* identical to REQ-004..006 for master 1 (DMA).
REQ-008 SHALL have ports s_cyc_o, s_stb_o, s_we_o  output  1, s_sel_o  output  4, s_adr_o and s_dat_o  output  32  SDRAM-side Wishbone request.
REQ-009 SHALL have ports s_ack_i  input  1, s_dat_i  input  32  SDRAM acknowledge and read data.
REQ-010 SHALL have port grant_o  output  2  one-hot status: bit0 = m0 owns bus, bit1 = m1 owns bus.

Function
REQ-011 SHALL implement states IDLE, GNT0, GNT1; reset state IDLE.
REQ-012 IDLE SHALL go to GNTx on the clock after mx_cyc_i is sampled high; s_cyc_o asserts in that following cycle (one-cycle arbitration latency).
REQ-013 When both cyc inputs are high in IDLE, SHALL grant the master not granted last (round-robin); last-grant register resets to m1, so m0 wins the first tie.
REQ-014 GNTx SHALL hold while mx_cyc_i is high; no preemption during a cycle.
REQ-015 When mx_cyc_i is low in GNTx: SHALL go directly to GNTy if my_cyc_i is high, otherwise to IDLE.
REQ-016 In GNTx, s_* request outputs SHALL be combinational copies of mx_* inputs; s_ack_i -> mx_ack_o and s_dat_i -> mx_dat_o in the same cycle (zero added latency).
REQ-017 Ungranted master SHALL see ack=0, err=0, dat_o=0; in IDLE all s_* outputs SHALL be 0.
REQ-018 Watchdog: a 16-bit counter SHALL increment each cycle s_stb_o=1 and s_ack_i=0, and clear on s_ack_i=1, on state change, or on expiry.
REQ-019 When the counter equals TIMEOUT, SHALL pulse mx_err_o for one cycle and force s_cyc_o=s_stb_o=0 that cycle; grant is retained.
REQ-020 If s_ack_i=1 in the expiry cycle, ack SHALL win; no error is raised.
REQ-021 grant_o SHALL be registered state-derived (00 in IDLE), never both bits set.

Reset
REQ-022 Assertion of rst SHALL immediately force state IDLE, last-grant=m1, watchdog=0, and all outputs 0, including mid-transfer.
REQ-023 After rst deasserts, the first grant SHALL occur no earlier than the second rising edge.

Structure
REQ-024 State encoding and master index constants (M0=0, M1=1) SHALL live in shared package sdram_arb_pkg.
REQ-025 The design SHALL be a single module; no sub-module is required.

Verification
REQ-026 Reset, m0 single read to 0x0000_0010, slave acks after 3 cycles with 0x1234_5678 -> m0_dat_o=0x1234_5678 with m0_ack_o, grant_o=01, m1_ack_o=0.
REQ-027 m0 and m1 raise cyc in the same cycle after reset -> m0 granted first; after m0 drops cyc, GNT1 directly with no IDLE cycle; next tie goes to m1.
REQ-028 m1 4-beat read burst with cyc held while m0 requests -> all 4 beats complete on m1 before m0 granted.
REQ-029 TIMEOUT=8, slave never acks -> m0_err_o pulses once exactly 8 stalled cycles after stb, s_stb_o low that cycle, grant_o stays 01.
REQ-030 Ack arrives in the exact expiry cycle -> ack delivered, no err; rst asserted mid-burst -> all outputs 0 in the same cycle, grant_o=00.
